logic_unit_checker: RTL and testbench

LOGIC_UNIT_CHECKER -- requirements
Module: logic_unit_checker

---
 rtl/logic_unit_checker.sv | 124 ++++++++++++
 tb/tb_logic_unit_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_checker.sv
// Built-in self-test sequencer for an 8-bit logic unit: drives LFSR operand pairs and checks AND/OR/XOR/NOT results.
// Optional build macro LOGIC_CHECK_STOP_ON_ERR_EN: end the run at the first mismatching vector.
module logic_unit_checker #(
  parameter int NUM_TESTS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] A,
  output logic [7:0] B,
  input  logic [7:0] Fand,
  input  logic [7:0] For,
  input  logic [7:0] Fxor,
  input  logic [7:0] Fnot,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] first_err_idx,
  output logic [3:0] first_err_mask
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [8:0] L_NUM_TESTS = 9'(NUM_TESTS);
  localparam logic [7:0] L_SEED      = 8'hAA;

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_idx;
  logic [7:0] r_errCount;
  logic [7:0] r_firstErrIdx;
  logic [3:0] r_firstErrMask;

  logic [3:0] w_mask;
  logic       w_mismatch;
  logic       w_stop;
  logic [8:0] w_idxNext;
  logic [7:0] w_nextA;

  function automatic logic [7:0] fnB(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h0F;
  endfunction

  assign w_mask     = {Fand != (r_a & r_b), For != (r_a | r_b),
                       Fxor != (r_a ^ r_b), Fnot != ~r_a};
  assign w_mismatch = |w_mask;
  assign w_idxNext  = {1'b0, r_idx} + 9'd1;
  assign w_nextA    = {r_a[6:0], r_a[7] ^ r_a[5] ^ r_a[4] ^ r_a[3]};

`ifdef LOGIC_CHECK_STOP_ON_ERR_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = DRIVE;
      DRIVE:   w_nextState = CHECK;
      CHECK:   w_nextState = (w_stop || (w_idxNext >= L_NUM_TESTS)) ? DONE : DRIVE;
      DONE:    if (start) w_nextState = DRIVE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // The first mismatch is recognisable by a zero count, since the count saturates instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a            <= 8'h00;
      r_b            <= 8'h00;
      r_idx          <= 8'h00;
      r_errCount     <= 8'h00;
      r_firstErrIdx  <= 8'h00;
      r_firstErrMask <= 4'h0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a            <= L_SEED;
            r_b            <= fnB(L_SEED);
            r_idx          <= 8'h00;
            r_errCount     <= 8'h00;
            r_firstErrIdx  <= 8'h00;
            r_firstErrMask <= 4'h0;
          end
        end
        CHECK: begin
          if (w_mismatch) begin
            if (r_errCount != 8'hFF) r_errCount <= r_errCount + 8'd1;
            if (r_errCount == 8'h00) begin
              r_firstErrIdx  <= r_idx;
              r_firstErrMask <= w_mask;
            end
          end
          if (w_nextState == DRIVE) begin
            r_idx <= w_idxNext[7:0];
            r_a   <= w_nextA;
            r_b   <= fnB(w_nextA);
          end
        end
        default: ;
      endcase
    end
  end

  assign A              = r_a;
  assign B              = r_b;
  assign busy           = (r_state == DRIVE) || (r_state == CHECK);
  assign done           = (r_state == DONE);
  assign pass           = done && (r_errCount == 8'h00);
  assign err_count      = r_errCount;
  assign first_err_idx  = r_firstErrIdx;
  assign first_err_mask = r_firstErrMask;

endmodule

// File: tb/tb_logic_unit_checker.sv
// Self-checking bench for logic_unit_checker: a fault-injectable logic unit model plus a vector-level reference model.
module tb_logic_unit_checker;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst, start, start1;
  logic [7:0] A, B, Fand, For, Fxor, Fnot;
  logic       busy, done, pass;
  logic [7:0] err_count, first_err_idx;
  logic [3:0] first_err_mask;
  logic [7:0] A1, B1, err1, fidx1;
  logic       busy1, done1, pass1;
  logic [3:0] fmask1;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] faultTbl [256];
  bit         xorZero = 1'b0;
  logic [7:0] modelA [N];
  logic [7:0] modelB [N];

  always #5 clk = ~clk;

  // Logic unit under test: exact results, except where a fault is planted for a given A value
  function automatic logic [31:0] lu(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] f;
    f = faultTbl[a];
    return {(a & b) ^ (f[3] ? 8'h01 : 8'h00),
            (a | b) ^ (f[2] ? 8'h80 : 8'h00),
            xorZero ? 8'h00 : ((a ^ b) ^ (f[1] ? 8'h10 : 8'h00)),
            (~a) ^ (f[0] ? 8'h02 : 8'h00)};
  endfunction

  always_comb {Fand, For, Fxor, Fnot} = lu(A, B);

  logic_unit_checker #(.NUM_TESTS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Fand(Fand), .For(For), .Fxor(Fxor), .Fnot(Fnot),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_mask(first_err_mask));

  logic_unit_checker #(.NUM_TESTS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1),
    .Fand(A1 & B1), .For(A1 | B1), .Fxor(A1 ^ B1), .Fnot(~A1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_idx(fidx1), .first_err_mask(fmask1));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic buildModel();
    logic [7:0] a;
    a = 8'hAA;
    for (int i = 0; i < N; i++) begin
      modelA[i] = a;
      modelB[i] = {a[3:0], a[7:4]} ^ 8'h0F;
      a = {a[6:0], a[7] ^ a[5] ^ a[4] ^ a[3]};
    end
  endtask

  // Walk the vector list and predict the outcome of one run
  task automatic predict(output int expErr, output int expIdx, output int expMask, output int expVecs);
    logic [31:0] got, ideal;
    logic [3:0]  m;
    expErr = 0; expIdx = 0; expMask = 0; expVecs = N;
    for (int i = 0; i < N; i++) begin
      ideal = {modelA[i] & modelB[i], modelA[i] | modelB[i], modelA[i] ^ modelB[i], ~modelA[i]};
      got   = lu(modelA[i], modelB[i]);
      for (int k = 0; k < 4; k++) m[k] = (got[8*k +: 8] != ideal[8*k +: 8]);
      if (m != 4'h0) begin
        if (expErr == 0) begin expIdx = i; expMask = int'(m); end
        if (expErr < 255) expErr++;
`ifdef LOGIC_CHECK_STOP_ON_ERR_EN
        expVecs = i + 1;
        break;
`endif
      end
    end
  endtask

  task automatic applyStimulus(input int injectAt, input int abortAt);
    int  expErr, expIdx, expMask, expVecs, cnt;
    bit  aborted;
    predict(expErr, expIdx, expMask, expVecs);
    aborted = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cnt = 0;
    checkOutput("doneCleared", 32'(done), 32'd0);
    checkOutput("errCleared", 32'(err_count), 32'd0);
    while (done !== 1'b1 && cnt < 200) begin
      if (cnt == abortAt) begin
        rst = 1'b1;
        #1;
        checkOutput("abortOutputs", {A, B, busy, done, pass, err_count, first_err_idx, first_err_mask}, 32'd0);
        @(negedge clk) rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (cnt % 2 == 0 && cnt / 2 < expVecs) begin
        checkOutput($sformatf("vecA%0d", cnt / 2), 32'(A), 32'(modelA[cnt / 2]));
        checkOutput($sformatf("vecB%0d", cnt / 2), 32'(B), 32'(modelB[cnt / 2]));
      end
      checkOutput("busyRun", 32'(busy), 32'd1);
      start = (cnt == injectAt);
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    if (!aborted) begin
      checkOutput("runCycles", 32'(cnt), 32'(2 * expVecs));
      checkOutput("errCount", 32'(err_count), 32'(expErr));
      checkOutput("firstIdx", 32'(first_err_idx), 32'(expIdx));
      checkOutput("firstMask", 32'(first_err_mask), 32'(expMask));
      checkOutput("pass", 32'(pass), 32'(expErr == 0));
      checkOutput("busyDone", 32'(busy), 32'd0);
    end
  endtask

  task automatic clearFaults();
    for (int i = 0; i < 256; i++) faultTbl[i] = 4'h0;
    xorZero = 1'b0;
  endtask

  initial begin
    int nf, cnt;
    clearFaults();
    buildModel();
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    #12;
    checkOutput("resetOutputs", {A, B, busy, done, pass, err_count, first_err_idx, first_err_mask}, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idleNeedsStart", {24'd0, busy, done, A[5:0]}, 32'd0);

    applyStimulus(-1, -1);
    applyStimulus(-1, -1);

    xorZero = 1'b1;
    applyStimulus(-1, -1);
    clearFaults();

    applyStimulus(5, -1);

    applyStimulus(-1, 7);
    repeat (3) @(negedge clk);
    checkOutput("idleAfterAbort", {busy, done, A}, 32'd0);
    applyStimulus(-1, -1);

    faultTbl[8'h55] = 4'b0001;
    applyStimulus(-1, -1);
    clearFaults();

    for (int r = 0; r < 6; r++) begin
      nf = $urandom_range(0, 3);
      for (int j = 0; j < nf; j++)
        faultTbl[modelA[$urandom_range(0, N - 1)]] = 4'($urandom_range(1, 15));
      applyStimulus(-1, -1);
      clearFaults();
    end

    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    cnt = 0;
    while (done1 !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("single_cycles", 32'(cnt), 32'd2);
    checkOutput("single_pass", {err1, 7'd0, pass1}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
